// File: rtl/beamscan_pkg.sv
// beamscan_pkg: shared lock-state encoding and default word width for BeamScanner counter checking
package beamscan_pkg;
   localparam int CNT_WIDTH = 16;
   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      TRACK   = 2'd1,
      LOCKED  = 2'd2,
      ILLEGAL = 2'd3
   } lock_state_e;
endpackage

// File: rtl/cnt_pattern_checker_if.sv
// cnt_pattern_checker_if: stream and status bundle of the counter pattern checker
//   D/DV/CLRCNT : sample word, sample qualifier, statistics clear (source -> checker)
//   LOCKED/ERR  : lock status and one-cycle mismatch pulse (checker -> host)
//   ERRCNT/SAMPCNT/LAST_BAD/LAST_EXP : statistics and last-mismatch capture (checker -> host)
interface cnt_pattern_checker_if import beamscan_pkg::*; #(
   parameter int WIDTH  = CNT_WIDTH,
   parameter int ECNT_W = 16
);
   logic [WIDTH-1:0]  D;
   logic              DV;
   logic              CLRCNT;
   logic              LOCKED;
   logic              ERR;
   logic [ECNT_W-1:0] ERRCNT;
   logic [ECNT_W-1:0] SAMPCNT;
   logic [WIDTH-1:0]  LAST_BAD;
   logic [WIDTH-1:0]  LAST_EXP;
   modport master (output D, DV, CLRCNT, input LOCKED, ERR, ERRCNT, SAMPCNT, LAST_BAD, LAST_EXP);
   modport slave  (input D, DV, CLRCNT, output LOCKED, ERR, ERRCNT, SAMPCNT, LAST_BAD, LAST_EXP);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a clear that applies before the same-cycle increment
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : clear to zero (the increment of the same cycle still applies)
//   inc_i    : increment by one, holding at all-ones
//   cnt_o    : count value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d, base;
   always_comb begin
      base  = clr_i ? '0 : cnt_q;
      cnt_d = (inc_i && base != '1) ? base + 1'b1 : base;
   end
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/cnt_pattern_checker.sv
// cnt_pattern_checker: locks onto an incrementing counter stream and flags, counts and captures mismatches
//   CLK, CLR : clock and synchronous active-high reset
//   bus      : slave side of cnt_pattern_checker_if (D/DV/CLRCNT in; LOCKED, ERR, ERRCNT,
//              SAMPCNT, LAST_BAD, LAST_EXP out, all registered)
module cnt_pattern_checker import beamscan_pkg::*; #(
   parameter int WIDTH      = CNT_WIDTH,
   parameter int LOCK_LEN   = 4,
   parameter int UNLOCK_LEN = 3,
   parameter int ECNT_W     = 16
) (
   input logic                   CLK,
   input logic                   CLR,
   cnt_pattern_checker_if.slave  bus
);
   localparam int RUN_W = $clog2(LOCK_LEN + UNLOCK_LEN + 1);
   lock_state_e      state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d, last_bad_q, last_bad_d, last_exp_q, last_exp_d;
   logic [RUN_W-1:0] good_q, good_d, bad_q, bad_d;
   logic             err_q, match, bad_hit;
   always_comb begin
      match   = bus.D == exp_q;
      state_d = state_q;
      exp_d   = exp_q;
      good_d  = good_q;
      bad_d   = bad_q;
      bad_hit = 1'b0;
      if (bus.DV) begin
         // every sample reseeds the expectation, so a fault costs one error, not a burst
         exp_d = bus.D + 1'b1;
         case (state_q)
            SEARCH: begin
               good_d  = '0;
               state_d = TRACK;
            end
            TRACK:
               if (!match) good_d = '0;
               else if (good_q == RUN_W'(LOCK_LEN - 2)) begin
                  state_d = LOCKED;
                  bad_d   = '0;
               end else good_d = good_q + 1'b1;
            LOCKED:
               if (match) bad_d = '0;
               else begin
                  bad_hit = 1'b1;
                  if (bad_q == RUN_W'(UNLOCK_LEN - 1)) begin
                     state_d = TRACK;
                     good_d  = '0;
                     bad_d   = '0;
                  end else bad_d = bad_q + 1'b1;
               end
            default: state_d = SEARCH;
         endcase
      end
      if (state_q == ILLEGAL) state_d = SEARCH;
      last_bad_d = bad_hit ? bus.D : (bus.CLRCNT ? '0 : last_bad_q);
      last_exp_d = bad_hit ? exp_q : (bus.CLRCNT ? '0 : last_exp_q);
   end
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q    <= SEARCH;
         exp_q      <= '0;
         good_q     <= '0;
         bad_q      <= '0;
         err_q      <= 1'b0;
         last_bad_q <= '0;
         last_exp_q <= '0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         err_q      <= bad_hit;
         last_bad_q <= last_bad_d;
         last_exp_q <= last_exp_d;
      end
   end
   sat_counter #(.W(ECNT_W)) u_errcnt (
      .clk   (CLK),
      .rst   (CLR),
      .clr_i (bus.CLRCNT),
      .inc_i (bad_hit),
      .cnt_o (bus.ERRCNT)
   );
   sat_counter #(.W(ECNT_W)) u_sampcnt (
      .clk   (CLK),
      .rst   (CLR),
      .clr_i (bus.CLRCNT),
      .inc_i (bus.DV),
      .cnt_o (bus.SAMPCNT)
   );
   assign bus.LOCKED   = state_q == LOCKED;
   assign bus.ERR      = err_q;
   assign bus.LAST_BAD = last_bad_q;
   assign bus.LAST_EXP = last_exp_q;
endmodule

// File: tb/tb_cnt_pattern_checker.sv
// tb_cnt_pattern_checker: table-driven and scoreboard-checked bench for cnt_pattern_checker
module tb_cnt_pattern_checker;
   localparam int LOCK_LEN   = 4;
   localparam int UNLOCK_LEN = 3;
   typedef struct packed {
      logic        lk, er;
      logic [15:0] ec, sc, lb, le;
      logic [3:0]  ec4, sc4;
   } exp_t;
   typedef struct {
      logic [15:0] d;
      logic        dv, cc, lk, er;
   } vec_t;
   logic clk = 1'b0, clr = 1'b1, dv = 1'b0, clrcnt = 1'b0;
   logic [15:0] d = '0;
   int n_cmp = 0, n_bad = 0;
   exp_t sb[$];
   vec_t tv[$];
   int m_st = 0, m_good = 0, m_bad = 0;
   logic [15:0] m_exp = '0, m_ec = '0, m_sc = '0, m_lb = '0, m_le = '0;
   logic [3:0]  m_ec4 = '0, m_sc4 = '0;
   logic        m_er = 1'b0;
   cnt_pattern_checker_if #(.WIDTH(16), .ECNT_W(16)) bus ();
   cnt_pattern_checker_if #(.WIDTH(16), .ECNT_W(4))  bus4 ();
   assign bus.D = d;
   assign bus.DV = dv;
   assign bus.CLRCNT = clrcnt;
   assign bus4.D = d;
   assign bus4.DV = dv;
   assign bus4.CLRCNT = clrcnt;
   cnt_pattern_checker #(.WIDTH(16), .LOCK_LEN(LOCK_LEN), .UNLOCK_LEN(UNLOCK_LEN), .ECNT_W(16)) dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus.slave)
   );
   cnt_pattern_checker #(.WIDTH(16), .LOCK_LEN(LOCK_LEN), .UNLOCK_LEN(UNLOCK_LEN), .ECNT_W(4)) dut4 (
      .CLK (clk),
      .CLR (clr),
      .bus (bus4.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", n, act, req);
      end
   endtask
   task automatic model(input logic [15:0] dd, input logic v, input logic cc, input logic r);
      if (r) begin
         m_st = 0; m_exp = '0; m_good = 0; m_bad = 0; m_er = 1'b0;
         m_ec = '0; m_sc = '0; m_lb = '0; m_le = '0; m_ec4 = '0; m_sc4 = '0;
         return;
      end
      if (cc) begin
         m_ec = '0; m_sc = '0; m_lb = '0; m_le = '0; m_ec4 = '0; m_sc4 = '0;
      end
      m_er = 1'b0;
      if (!v) return;
      if (m_sc != 16'hFFFF) m_sc++;
      if (m_sc4 != 4'hF) m_sc4++;
      if (m_st == 0) begin
         m_good = 0;
         m_st = 1;
      end else if (m_st == 1) begin
         if (dd != m_exp) m_good = 0;
         else begin
            m_good++;
            if (m_good == LOCK_LEN - 1) begin
               m_st = 2;
               m_bad = 0;
            end
         end
      end else if (dd == m_exp) m_bad = 0;
      else begin
         m_er = 1'b1;
         if (m_ec != 16'hFFFF) m_ec++;
         if (m_ec4 != 4'hF) m_ec4++;
         m_lb = dd;
         m_le = m_exp;
         m_bad++;
         if (m_bad == UNLOCK_LEN) begin
            m_st = 1; m_good = 0; m_bad = 0;
         end
      end
      m_exp = dd + 16'd1;
   endtask
   task automatic cyc(input logic [15:0] dd, input logic v, input logic cc, input logic r);
      exp_t e;
      d = dd; dv = v; clrcnt = cc; clr = r;
      model(dd, v, cc, r);
      sb.push_back('{m_st == 2, m_er, m_ec, m_sc, m_lb, m_le, m_ec4, m_sc4});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_locked", bus.LOCKED, e.lk);
      chk("sb_err", bus.ERR, e.er);
      chk("sb_errcnt", bus.ERRCNT, e.ec);
      chk("sb_sampcnt", bus.SAMPCNT, e.sc);
      chk("sb_last_bad", bus.LAST_BAD, e.lb);
      chk("sb_last_exp", bus.LAST_EXP, e.le);
      chk("sb_errcnt4", bus4.ERRCNT, e.ec4);
      chk("sb_sampcnt4", bus4.SAMPCNT, e.sc4);
   endtask
   task automatic add(input logic [15:0] dd, input logic v, input logic cc, input logic lk, input logic er);
      tv.push_back('{dd, v, cc, lk, er});
   endtask
   task automatic run_tv(input string tag);
      for (int i = 0; i < tv.size(); i++) begin
         cyc(tv[i].dv ? tv[i].d : 16'($urandom), tv[i].dv, tv[i].cc, 1'b0);
         chk($sformatf("%s[%0d]_locked", tag, i), bus.LOCKED, tv[i].lk);
         chk($sformatf("%s[%0d]_err", tag, i), bus.ERR, tv[i].er);
      end
      tv.delete();
   endtask
   task automatic rst_cycle();
      cyc(16'h0, 1'b0, 1'b0, 1'b1);
   endtask
   initial begin
      rst_cycle();
      chk("reset_locked", bus.LOCKED, 0);
      chk("reset_errcnt", bus.ERRCNT, 0);
      add(16'h0010, 1, 0, 0, 0); add(16'h0011, 1, 0, 0, 0);
      add(16'h0012, 1, 0, 0, 0); add(16'h0013, 1, 0, 1, 0);
      run_tv("acq");
      chk("acq_sampcnt", bus.SAMPCNT, 4);
      rst_cycle();
      add(16'hFFFA, 1, 0, 0, 0); add(16'hFFFB, 1, 0, 0, 0);
      add(16'hFFFC, 1, 0, 0, 0); add(16'hFFFD, 1, 0, 1, 0);
      add(16'hFFFE, 1, 0, 1, 0); add(16'hFFFF, 1, 0, 1, 0);
      add(16'h0000, 1, 0, 1, 0); add(16'h0001, 1, 0, 1, 0);
      run_tv("wrap");
      chk("wrap_errcnt", bus.ERRCNT, 0);
      rst_cycle();
      add(16'h00FD, 1, 0, 0, 0); add(16'h00FE, 1, 0, 0, 0);
      add(16'h00FF, 1, 0, 0, 0); add(16'h0100, 1, 0, 1, 0);
      add(16'h0101, 1, 0, 1, 0); add(16'h0150, 1, 0, 1, 1);
      add(16'h0151, 1, 0, 1, 0);
      run_tv("fault");
      chk("fault_errcnt", bus.ERRCNT, 1);
      chk("fault_last_bad", bus.LAST_BAD, 16'h0150);
      chk("fault_last_exp", bus.LAST_EXP, 16'h0102);
      rst_cycle();
      add(16'h0200, 1, 0, 0, 0); add(16'h0201, 1, 0, 0, 0);
      add(16'h0202, 1, 0, 0, 0); add(16'h0203, 1, 0, 1, 0);
      add(16'h1234, 1, 0, 1, 1); add(16'h0000, 1, 0, 1, 1);
      add(16'h7777, 1, 0, 0, 1); add(16'h7778, 1, 0, 0, 0);
      add(16'h7779, 1, 0, 0, 0); add(16'h777A, 1, 0, 1, 0);
      add(16'h777B, 1, 0, 1, 0);
      run_tv("unlock");
      chk("unlock_errcnt", bus.ERRCNT, 3);
      add(16'h777C, 1, 0, 1, 0); add(16'h0000, 0, 0, 1, 0);
      add(16'h777D, 1, 0, 1, 0); add(16'h0000, 0, 0, 1, 0);
      add(16'h0000, 0, 0, 1, 0); add(16'h777E, 1, 0, 1, 0);
      add(16'h9999, 1, 1, 1, 1);
      run_tv("gate");
      chk("clrcnt_errcnt", bus.ERRCNT, 1);
      chk("clrcnt_sampcnt", bus.SAMPCNT, 1);
      chk("clrcnt_errcnt4", bus4.ERRCNT, 1);
      cyc(16'h999A, 1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 10; r++) begin
         logic [15:0] b;
         b = 16'(32'h3000 + r * 256);
         cyc(b, 1'b1, 1'b0, 1'b0);
         cyc(b, 1'b1, 1'b0, 1'b0);
         cyc(b + 16'd1, 1'b1, 1'b0, 1'b0);
      end
      chk("sat_errcnt4", bus4.ERRCNT, 4'hF);
      chk("sat_sampcnt4", bus4.SAMPCNT, 4'hF);
      chk("sat_errcnt16", bus.ERRCNT, 21);
      chk("sat_locked", bus.LOCKED, 1);
      cyc(16'h5000, 1'b1, 1'b0, 1'b1);
      chk("clr_locked", bus.LOCKED, 0);
      chk("clr_err", bus.ERR, 0);
      chk("clr_errcnt", bus.ERRCNT, 0);
      chk("clr_sampcnt", bus.SAMPCNT, 0);
      chk("clr_last_bad", bus.LAST_BAD, 0);
      chk("clr_last_exp", bus.LAST_EXP, 0);
      add(16'h5000, 1, 0, 0, 0); add(16'h5001, 1, 0, 0, 0);
      add(16'h5002, 1, 0, 0, 0); add(16'h5003, 1, 0, 1, 0);
      run_tv("relock");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
